led_frame_streamer: RTL and testbench
=====================================

LED_FRAME_STREAMER -- requirements
Module: led_frame_streamer

Interface
REQ-001 Parameter NUM_LEDS, default 8, number of pixels in the frame buffer (at least 1).
REQ-002 Parameter T0H_CYC, default 19, number of clk cycles dout is high for a 0 bit (0.4 us at 48 MHz).
REQ-003 Parameter T1H_CYC, default 38, number of clk cycles dout is high for a 1 bit (0.8 us).
REQ-004 Parameter BIT_CYC, default 60, total clk cycles per bit (1.25 us). It must exceed T1H_CYC.
REQ-005 Parameter RST_CYC, default 14400, number of low cycles in the latch gap (300 us).
REQ-006 Derived width AW = max(1, clog2(NUM_LEDS)).
REQ-007 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-008 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port wr_en, input, 1 bit: pixel write strobe.
REQ-010 Port wr_addr, input, AW bits: index of the pixel to write.
REQ-011 Port wr_data, input, 24 bits: pixel colour as {R[23:16], G[15:8], B[7:0]}.
REQ-012 Port start, input, 1 bit: frame request.
REQ-013 Port busy, output, 1 bit: high from frame acceptance until the latch gap ends.
REQ-014 Port frame_done, output, 1 bit: one-cycle pulse at the end of the latch gap.
REQ-015 Port dout, output, 1 bit: registered serial line to the LED string.

Function
REQ-016 The frame buffer SHALL be NUM_LEDS x 24 bits, written on a rising clk edge when wr_en=1 and wr_addr<NUM_LEDS.
REQ-017 Writes with wr_addr>=NUM_LEDS SHALL be ignored.
REQ-018 Writes SHALL be accepted in every state, including during streaming.
REQ-019 The FSM SHALL have the states IDLE, LOAD, SEND and LATCH.
REQ-020 In IDLE, start=1 SHALL move the FSM to LOAD. busy rises on the same edge.
REQ-021 LOAD SHALL last exactly 1 cycle, fetch pixel 0 into a shift register reordered to GRB, and move to SEND.
REQ-022 SEND SHALL transmit 24 bits per pixel, MSB first: G7..G0, then R7..R0, then B7..B0, for pixels 0 to NUM_LEDS-1 in order.
REQ-023 Each bit SHALL last exactly BIT_CYC cycles. dout is 1 for the first T0H_CYC cycles (bit=0) or T1H_CYC cycles (bit=1) of the bit, and 0 for the rest.
REQ-024 Bits SHALL be contiguous across pixel boundaries, with no gap. The next pixel is prefetched from the buffer during the last bit of the current pixel.
REQ-025 Each pixel's value SHALL be sampled at its fetch. A write to a pixel before it is fetched appears in the current frame; a write after it is fetched appears in the next frame.
REQ-026 The first dout=1 SHALL occur on the first SEND cycle, 2 rising edges after start is sampled in IDLE.
REQ-027 After the last bit of pixel NUM_LEDS-1, the FSM SHALL enter LATCH and hold dout=0 for exactly RST_CYC cycles.
REQ-028 frame_done SHALL pulse for 1 cycle on the final LATCH cycle, after which the FSM returns to IDLE and busy falls.
REQ-029 start SHALL be ignored while busy=1. Requests are not queued.
REQ-030 The bit counter, pixel counter and timing counter SHALL be sized to their maxima, and SHALL wrap only by explicit reload, never by overflow.

Reset
REQ-031 reset=0 SHALL asynchronously force the FSM to IDLE, dout=0, busy=0, frame_done=0, and clear all counters.
REQ-032 A reset during any state, including mid-bit with dout=1, SHALL drop dout to 0 immediately and abort the frame.
REQ-033 Frame buffer contents SHALL NOT be cleared by reset.

Configuration
REQ-034 Macro LED_AUTO_REFRESH_EN, when defined, SHALL move the FSM from LATCH to LOAD instead of IDLE. Frames then repeat continuously with busy held at 1, and frame_done still pulses once per frame.
REQ-035 With LED_AUTO_REFRESH_EN defined, the frame period SHALL be NUM_LEDS*24*BIT_CYC + RST_CYC + 1 cycles.
REQ-036 Without LED_AUTO_REFRESH_EN, each frame SHALL require its own start.

Verification
REQ-037 Reset: assert reset=0 mid-stream, with dout high -> dout=0, busy=0 and frame_done=0 at once. The buffer is retained, so a restart sends the same data.
REQ-038 NUM_LEDS=2, pixel0=24'hFF0000, pixel1=24'h0000FF, start -> 48 bits: 8x0, 8x1, 8x0, 16x0, 8x1. High widths are 19 or 38 cycles, each bit is 60 cycles, for 2880 cycles total. dout is then low for 14400 cycles, and frame_done pulses once.
REQ-039 Pulse start every 100 cycles during a frame -> exactly 1 frame is sent and exactly 1 frame_done pulse occurs.
REQ-040 During pixel 1 of a frame, write pixel0=24'h00FF00 -> the current frame is unchanged, and the next frame's first 8 bits are all 1.
REQ-041 Write wr_addr=NUM_LEDS with NUM_LEDS=5 -> no pixel changes.
REQ-042 With LED_AUTO_REFRESH_EN defined and NUM_LEDS=2 -> frame_done pulses every 17281 cycles, and busy stays 1.

Source files
------------

// File: rtl/led_frame_streamer.sv
// led_frame_streamer: WS2812-style serial driver fed from a NUM_LEDS x 24-bit frame buffer.
// Define LED_AUTO_REFRESH_EN to restart the frame after every latch gap instead of idling.
module led_frame_streamer #(
  parameter int NUM_LEDS = 8,
  parameter int T0H_CYC  = 19,
  parameter int T1H_CYC  = 38,
  parameter int BIT_CYC  = 60,
  parameter int RST_CYC  = 14400,
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output logic          dout
);

  localparam int TW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int LW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] T_ZERO = TW'(T0H_CYC);
  localparam logic [TW-1:0] T_ONE  = TW'(T1H_CYC);
  localparam logic [LW-1:0] L_LAST = LW'(RST_CYC - 1);
  localparam logic [AW-1:0] P_LAST = AW'(NUM_LEDS - 1);
  localparam logic [AW:0]   P_LIM  = (AW + 1)'(NUM_LEDS);
  localparam logic [4:0]    B_LAST = 5'd23;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    LATCH
  } state_t;

  state_t        state;
  logic [23:0]   shreg;
  logic [TW-1:0] tcnt;
  logic [4:0]    bcnt;
  logic [AW-1:0] pix_cnt;
  logic [LW-1:0] lcnt;

  logic [23:0]   fb [2**AW];

  logic [AW-1:0] pix_nxt;
  logic [TW-1:0] t_nxt;
  logic [TW-1:0] t_high;
  logic [LW-1:0] l_nxt;

  assign pix_nxt = pix_cnt + 1'b1;
  assign t_nxt   = tcnt + 1'b1;
  assign t_high  = shreg[23] ? T_ONE : T_ZERO;
  assign l_nxt   = lcnt + 1'b1;

  function automatic logic [23:0] grb(input logic [23:0] c);
    return {c[15:8], c[23:16], c[7:0]};
  endfunction

  // Pixel store: open to writes in every state, survives reset.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < P_LIM)) begin
      fb[wr_addr] <= wr_data;
    end
  end

  // Frame sequencer: bit timing, pixel fetch, latch gap and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dout       <= 1'b0;
      shreg      <= '0;
      tcnt       <= '0;
      bcnt       <= '0;
      pix_cnt    <= '0;
      lcnt       <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          shreg   <= grb(fb[0]);
          tcnt    <= '0;
          bcnt    <= '0;
          pix_cnt <= '0;
          dout    <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (tcnt == T_LAST) begin
            tcnt <= '0;
            if (bcnt == B_LAST) begin
              bcnt <= '0;
              if (pix_cnt == P_LAST) begin
                pix_cnt    <= '0;
                lcnt       <= '0;
                dout       <= 1'b0;
                frame_done <= (RST_CYC == 1);
                state      <= LATCH;
              end else begin
                pix_cnt <= pix_nxt;
                shreg   <= grb(fb[pix_nxt]);
                dout    <= 1'b1;
              end
            end else begin
              bcnt  <= bcnt + 1'b1;
              shreg <= {shreg[22:0], 1'b0};
              dout  <= 1'b1;
            end
          end else begin
            tcnt <= t_nxt;
            dout <= (t_nxt < t_high);
          end
        end
        LATCH: begin
          if (lcnt == L_LAST) begin
            lcnt <= '0;
`ifdef LED_AUTO_REFRESH_EN
            state <= LOAD;
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            lcnt       <= l_nxt;
            frame_done <= (l_nxt == L_LAST);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_streamer.sv
// tb_led_frame_streamer: scoreboard bench decoding dout into bits and latch gaps.
// Expected GRB words are queued at stimulus time; a negedge monitor pops and compares.
module tb_led_frame_streamer;

  localparam int T0   = 19;
  localparam int T1   = 38;
  localparam int BC   = 60;
  localparam int RST2 = 2400;
  localparam int RST5 = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        wr_en2, start2, busy2, done2, dout2;
  logic [0:0]  wr_addr2;
  logic [23:0] wr_data2;
  logic        wr_en5, start5, busy5, done5, dout5;
  logic [2:0]  wr_addr5;
  logic [23:0] wr_data5;

  led_frame_streamer #(
    .NUM_LEDS(2), .T0H_CYC(T0), .T1H_CYC(T1),
    .BIT_CYC(BC), .RST_CYC(RST2)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en2),
    .wr_addr(wr_addr2), .wr_data(wr_data2), .start(start2),
    .busy(busy2), .frame_done(done2), .dout(dout2)
  );

  led_frame_streamer #(
    .NUM_LEDS(5), .T0H_CYC(T0), .T1H_CYC(T1),
    .BIT_CYC(BC), .RST_CYC(RST5)
  ) dut5 (
    .clk(clk), .reset(reset), .wr_en(wr_en5),
    .wr_addr(wr_addr5), .wr_data(wr_data5), .start(start5),
    .busy(busy5), .frame_done(done5), .dout(dout5)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard
  bit   exp_q[$];
  logic sel5;
  logic mon_en;
  int   done_cnt = 0;
  int   hi, lo;
  bit   inbit;
  logic prev;

  wire m_dout = sel5 ? dout5 : dout2;
  wire m_done = sel5 ? done5 : done2;

  task automatic push_grb(input logic [23:0] g);
    for (int i = 23; i >= 0; i--) exp_q.push_back(g[i]);
  endtask

  task automatic close_bit(input int h, input int l, input bit last);
    bit e;
    int rst;
    rst = sel5 ? RST5 : RST2;
    chk("bit_expected", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("bit_high", h, e ? T1 : T0);
      if (last) chk("latch_gap", h + l, BC + rst);
      else chk("bit_period", h + l, BC);
    end
  endtask

  always @(negedge clk) begin
    if (!reset || !mon_en) begin
      hi = 0; lo = 0; inbit = 0; prev = 1'b0;
    end else begin
      if (m_dout && !prev) begin
        if (inbit) close_bit(hi, lo, 1'b0);
        inbit = 1; hi = 1; lo = 0;
      end else if (m_dout) begin
        hi++;
      end else if (inbit) begin
        lo++;
      end
      if (m_done) begin
        done_cnt++;
        if (inbit) close_bit(hi, lo, 1'b1);
        inbit = 0;
        chk("frame_bits_left", exp_q.size(), 0);
      end
      prev = m_dout;
    end
  end

  task automatic wait_done(input int budget, input string name);
    int c0;
    int n;
    c0 = done_cnt;
    n  = 0;
    while (done_cnt == c0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, done_cnt - c0, 1);
  endtask

  task automatic write2(input logic [0:0] a, input logic [23:0] d);
    @(negedge clk);
    wr_en2 = 1'b1; wr_addr2 = a; wr_data2 = d;
    @(negedge clk);
    wr_en2 = 1'b0;
  endtask

  task automatic write5(input logic [2:0] a, input logic [23:0] d);
    @(negedge clk);
    wr_en5 = 1'b1; wr_addr5 = a; wr_data5 = d;
    @(negedge clk);
    wr_en5 = 1'b0;
  endtask

  task automatic start_main();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  localparam int F2 = 48 * BC + RST2 + 20;
  localparam int F5 = 120 * BC + RST5 + 20;

  logic auto_watch = 1'b0;
  logic busy_low   = 1'b0;
  always @(negedge clk) if (auto_watch && !busy2) busy_low = 1'b1;

  initial begin
    int c0;
    int n;
    int t1;
    reset = 1'b0;
    wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; start2 = 1'b0;
    wr_en5 = 1'b0; wr_addr5 = '0; wr_data5 = '0; start5 = 1'b0;
    sel5 = 1'b0; mon_en = 1'b1;
    #12;
    chk("reset_dout", dout2, 0);
    chk("reset_busy", busy2, 0);
    chk("reset_done", done2, 0);
    @(negedge clk);
    reset = 1'b1;

    write2(1'b0, 24'hFF0000);
    write2(1'b1, 24'h0000FF);

`ifdef LED_AUTO_REFRESH_EN
    mon_en = 1'b0;
    start_main();
    auto_watch = 1'b1;
    n = 0;
    while (!done2 && n < F2) begin @(negedge clk); n++; end
    chk("auto_first_done", done2, 1);
    t1 = cyc;
    @(negedge clk);
    n = 0;
    while (!done2 && n < F2) begin @(negedge clk); n++; end
    chk("auto_second_done", done2, 1);
    chk("auto_period", cyc - t1, 48 * BC + RST2 + 1);
    chk("auto_busy_low_seen", busy_low, 0);
`else
    // frame 1: timing, latency and latch gap
    push_grb(24'h00FF00);
    push_grb(24'h0000FF);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("busy_rise", busy2, 1);
    chk("load_dout_low", dout2, 0);
    @(negedge clk);
    chk("first_send_high", dout2, 1);
    wait_done(F2, "frame1_done");
    @(negedge clk);
    chk("busy_fall", busy2, 0);

    // frame 2: start pulses while busy are ignored
    c0 = done_cnt;
    push_grb(24'h00FF00);
    push_grb(24'h0000FF);
    start_main();
    for (int k = 0; k < 200 && busy2; k++) begin
      repeat (99) @(negedge clk);
      if (busy2) begin
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
      end
    end
    repeat (200) @(negedge clk);
    chk("start_ignored_frames", done_cnt - c0, 1);
    chk("start_ignored_idle", busy2, 0);

    // frame 3: rewrite pixel 0 while pixel 1 streams
    push_grb(24'h00FF00);
    push_grb(24'h0000FF);
    start_main();
    repeat (1700) @(negedge clk);
    write2(1'b0, 24'h00FF00);
    wait_done(F2, "frame3_done");
    @(negedge clk);

    // frame 4: rewritten pixel now visible
    push_grb(24'hFF0000);
    push_grb(24'h0000FF);
    start_main();
    wait_done(F2, "frame4_done");
    @(negedge clk);

    // abort a frame with dout high, then resend from the retained buffer
    mon_en = 1'b0;
    start_main();
    repeat (300) @(negedge clk);
    n = 0;
    while (!dout2 && n < 100) begin @(negedge clk); n++; end
    chk("dout_high_before_reset", dout2, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_dout", dout2, 0);
    chk("abort_busy", busy2, 0);
    chk("abort_done", done2, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    push_grb(24'hFF0000);
    push_grb(24'h0000FF);
    start_main();
    wait_done(F2, "restart_done");
    repeat (5) @(negedge clk);

    // five-pixel instance: out-of-range writes are dropped
    sel5 = 1'b1;
    write5(3'd0, 24'h123456);
    write5(3'd1, 24'hA5C3F0);
    write5(3'd2, 24'h000001);
    write5(3'd3, 24'h800000);
    write5(3'd4, 24'h00FF00);
    write5(3'd5, 24'hFFFFFF);
    write5(3'd7, 24'hFFFFFF);
    push_grb(24'h341256);
    push_grb(24'hC3A5F0);
    push_grb(24'h000001);
    push_grb(24'h008000);
    push_grb(24'hFF0000);
    @(negedge clk);
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    wait_done(F5, "n5_done");
    @(negedge clk);
    chk("n5_busy_fall", busy5, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
